// File: rtl/parity_sched.sv
// Round-robin scheduler sharing one external 16-input parity tree among NREQ packet requesters.
// Optional PARITY_SCHED_ERRCNT_EN adds a saturating err_cnt output counting error responses.
module parity_sched #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*16-1:0]   req_data,
   input  logic [NREQ-1:0]      req_last,
   input  logic [NREQ-1:0]      req_exp,
   output logic [NREQ-1:0]      req_ready,
   output logic [15:0]          par_in,
   input  logic                 par_q,
   output logic                 rsp_valid,
   output logic [IDW-1:0]       rsp_id,
   output logic                 rsp_parity,
   output logic                 rsp_err,
   input  logic                 rsp_ready,
   output logic                 busy
`ifdef PARITY_SCHED_ERRCNT_EN
   ,
   output logic [15:0]          err_cnt
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_RESP} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [IDW-1:0]  r_ptr;
   logic [IDW-1:0]  r_gnt;
   logic [IDW-1:0]  w_pick;
   logic            w_any;
   logic            r_acc;
   logic            r_rsp_parity;
   logic            r_rsp_err;
   logic [15:0]     w_words [NREQ];
   logic            w_vld_g;
   logic            w_last_g;
   logic            w_exp_g;
   logic            w_take;
   logic            w_par_word;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         w_words[i] = req_data[16*i +: 16];
      end
   end

   assign w_vld_g    = req_valid[r_gnt];
   assign w_last_g   = req_last[r_gnt];
   assign w_exp_g    = req_exp[r_gnt];
   assign w_take     = (r_state == S_STREAM) && w_vld_g;
   assign w_par_word = r_acc ^ par_q;
   assign w_any      = |req_valid;

   // Lowest valid index above r_ptr wins; otherwise the lowest valid index at or below it.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      w_pick = '0;
      for (int i = NREQ-1; i >= 0; i--) begin
         if (req_valid[i] && (IDW'(i) <= r_ptr)) w_pick = IDW'(i);
      end
      for (int i = NREQ-1; i >= 0; i--) begin
         if (req_valid[i] && (IDW'(i) > r_ptr)) w_pick = IDW'(i);
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:   if (w_any)               w_state_nxt = S_STREAM;
         S_STREAM: if (w_vld_g && w_last_g) w_state_nxt = S_RESP;
         S_RESP:   if (rsp_ready)           w_state_nxt = S_IDLE;
         default:                           w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready = '0;
      par_in    = '0;
      rsp_valid = (r_state == S_RESP);
      busy      = (r_state != S_IDLE);
      if (r_state == S_STREAM) begin
         req_ready[r_gnt] = 1'b1;
         if (w_vld_g) par_in = w_words[r_gnt];
      end
   end

   assign rsp_id     = r_gnt;
   assign rsp_parity = r_rsp_parity;
   assign rsp_err    = r_rsp_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr        <= IDW'(NREQ-1);
         r_gnt        <= '0;
         r_acc        <= 1'b0;
         r_rsp_parity <= 1'b0;
         r_rsp_err    <= 1'b0;
      end else begin
         if ((r_state == S_IDLE) && w_any) begin
            r_gnt <= w_pick;
            r_acc <= 1'b0;
         end
         if (w_take) begin
            r_acc <= w_par_word;
            if (w_last_g) begin
               r_rsp_parity <= w_par_word;
               r_rsp_err    <= w_par_word ^ w_exp_g;
            end
         end
         if ((r_state == S_RESP) && rsp_ready) r_ptr <= r_gnt;
      end
   end

`ifdef PARITY_SCHED_ERRCNT_EN
   logic [15:0] r_err_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_err_cnt <= '0;
      end else if ((r_state == S_RESP) && rsp_ready && r_rsp_err && (r_err_cnt != 16'hFFFF)) begin
         r_err_cnt <= r_err_cnt + 16'd1;
      end
   end

   assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_parity_sched.sv
// Scoreboard bench for parity_sched: queued per-requester packets, monitor checks cycle rules and results.
// Build with PARITY_SCHED_ERRCNT_EN defined to also check err_cnt.
module tb_parity_sched;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ*16-1:0]  req_data;
   logic [NREQ-1:0]     req_last;
   logic [NREQ-1:0]     req_exp;
   logic [NREQ-1:0]     req_ready;
   logic [15:0]         par_in;
   logic                par_q;
   logic                rsp_valid;
   logic [IDW-1:0]      rsp_id;
   logic                rsp_parity;
   logic                rsp_err;
   logic                rsp_ready;
   logic                busy;
`ifdef PARITY_SCHED_ERRCNT_EN
   logic [15:0]         err_cnt;
`endif

   always #5 clk = ~clk;

   // The shared parity tree lives outside the scheduler.
   assign par_q = ^par_in;

   parity_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_last   (req_last),
      .req_exp    (req_exp),
      .req_ready  (req_ready),
      .par_in     (par_in),
      .par_q      (par_q),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_parity (rsp_parity),
      .rsp_err    (rsp_err),
      .rsp_ready  (rsp_ready),
      .busy       (busy)
`ifdef PARITY_SCHED_ERRCNT_EN
      ,
      .err_cnt    (err_cnt)
`endif
   );

   typedef struct packed {
      logic [15:0] data;
      logic        last;
      logic        exp;
      logic [3:0]  gap;
   } word_t;

   typedef struct packed {
      logic parity;
      logic err;
   } exp_t;

   typedef enum {M_IDLE, M_STREAM, M_RESP} mphase_t;

   word_t        wq [NREQ][$];
   exp_t         sb [NREQ][$];
   logic         model_acc [NREQ];
   int           id_log [$];
   int           checks   = 0;
   int           failures = 0;
   int           rsp_pct  = 100;
   logic [15:0]  dwords [NREQ];

   always_comb begin
      for (int i = 0; i < NREQ; i++) dwords[i] = req_data[16*i +: 16];
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic add_word(input logic [IDW-1:0] r, input logic [15:0] d, input logic last,
                           input logic e, input int gap);
      word_t w;
      exp_t  x;
      w.data = d;
      w.last = last;
      w.exp  = e;
      w.gap  = 4'(gap);
      wq[r].push_back(w);
      model_acc[r] = model_acc[r] ^ (^d);
      if (last) begin
         x.parity = model_acc[r];
         x.err    = model_acc[r] ^ e;
         sb[r].push_back(x);
         model_acc[r] = 1'b0;
      end
   endtask

   function automatic bit all_done();
      for (int r = 0; r < NREQ; r++) begin
         if (wq[r].size() != 0 || sb[r].size() != 0) return 1'b0;
      end
      return 1'b1;
   endfunction

   // One cycle of requester behaviour, called at posedge+1 and returning at the next posedge+1.
   task automatic step();
      logic [NREQ-1:0] take;
      word_t           w;
      req_valid = '0;
      req_last  = '0;
      req_exp   = '0;
      req_data  = '0;
      for (int r = 0; r < NREQ; r++) begin
         if (wq[r].size() != 0) begin
            w = wq[r][0];
            if (w.gap != 4'd0) begin
               w.gap    = w.gap - 4'd1;
               wq[r][0] = w;
            end else begin
               req_valid[r]          = 1'b1;
               req_data[16*r +: 16]  = w.data;
               req_last[r]           = w.last;
               req_exp[r]            = w.exp;
            end
         end
      end
      rsp_ready = ($urandom_range(99) < rsp_pct);
      take = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int r = 0; r < NREQ; r++) begin
         if (take[r]) void'(wq[r].pop_front());
      end
   endtask

   task automatic run(input int budget);
      int n = 0;
      while (!all_done() && n < budget) begin
         step();
         n++;
      end
      check("run_done", 32'(all_done()), 32'd1);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      req_last  = '0;
      req_exp   = '0;
      req_data  = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int r = 0; r < NREQ; r++) model_acc[r] = 1'b0;
      id_log.delete();
   endtask

   // Monitor: cycle-level rules of the scheduler plus result comparison against the scoreboard.
   mphase_t         ph = M_IDLE;
   logic [IDW-1:0]  owner = '0;
   logic [IDW-1:0]  last_served = IDW'(NREQ-1);
   logic [IDW-1:0]  cand;
   bit              found;
   int              err_model = 0;
   exp_t            popped;

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            ph          = M_IDLE;
            last_served = IDW'(NREQ-1);
            err_model   = 0;
         end else begin
`ifdef PARITY_SCHED_ERRCNT_EN
            check("err_cnt", 32'(err_cnt), 32'(err_model));
`endif
            case (ph)
               M_IDLE: begin
                  check("idle_busy", 32'(busy), 32'd0);
                  check("idle_ready", 32'(req_ready), 32'd0);
                  check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
                  check("idle_par_in", 32'(par_in), 32'd0);
                  if (req_valid != '0) begin
                     found = 1'b0;
                     for (int k = 1; k <= NREQ; k++) begin
                        cand = last_served + IDW'(k);
                        if (!found && req_valid[cand]) begin
                           owner = cand;
                           found = 1'b1;
                        end
                     end
                     ph = M_STREAM;
                  end
               end
               M_STREAM: begin
                  check("stream_busy", 32'(busy), 32'd1);
                  check("stream_ready", 32'(req_ready), 32'(4'b0001 << owner));
                  check("stream_rsp_valid", 32'(rsp_valid), 32'd0);
                  check("stream_par_in", 32'(par_in), req_valid[owner] ? 32'(dwords[owner]) : 32'd0);
                  if (req_valid[owner] && req_last[owner]) ph = M_RESP;
               end
               default: begin
                  check("resp_busy", 32'(busy), 32'd1);
                  check("resp_ready", 32'(req_ready), 32'd0);
                  check("resp_valid", 32'(rsp_valid), 32'd1);
                  check("resp_id", 32'(rsp_id), 32'(owner));
                  check("resp_par_in", 32'(par_in), 32'd0);
                  if (sb[owner].size() == 0) begin
                     check("resp_expected", 32'(sb[owner].size()), 32'd1);
                  end else begin
                     check("rsp_parity", 32'(rsp_parity), 32'(sb[owner][0].parity));
                     check("rsp_err", 32'(rsp_err), 32'(sb[owner][0].err));
                  end
                  if (rsp_ready) begin
                     if (sb[owner].size() != 0) begin
                        popped = sb[owner].pop_front();
                        if (popped.err && err_model < 65535) err_model++;
                     end
                     id_log.push_back(int'(owner));
                     last_served = owner;
                     ph = M_IDLE;
                  end
               end
            endcase
         end
      end
   end

   logic [15:0] pkt6 [4];

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_last  = '0;
      req_exp   = '0;
      req_data  = '0;
      rsp_ready = 1'b0;
      for (int r = 0; r < NREQ; r++) model_acc[r] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_par_in", 32'(par_in), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_id", 32'(rsp_id), 32'd0);
      check("rst_rsp_parity", 32'(rsp_parity), 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
`ifdef PARITY_SCHED_ERRCNT_EN
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif

      // Single-word packet from requester 0: ready one cycle after grant, response one after accept.
      rsp_pct = 100;
      add_word(2'd0, 16'h0001, 1'b1, 1'b1, 0);
      step();
      check("t1_ready", 32'(req_ready), 32'h1);
      step();
      check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
      check("t1_rsp_id", 32'(rsp_id), 32'd0);
      check("t1_rsp_parity", 32'(rsp_parity), 32'd1);
      check("t1_rsp_err", 32'(rsp_err), 32'd0);
      run(50);

      // Requester 2, three words with a 2-cycle valid gap after the first.
      add_word(2'd2, 16'h00FF, 1'b0, 1'b0, 0);
      add_word(2'd2, 16'h0003, 1'b0, 1'b0, 2);
      add_word(2'd2, 16'h8000, 1'b1, 1'b0, 0);
      check("t2_expect_parity", 32'(sb[2][0].parity), 32'd1);
      check("t2_expect_err", 32'(sb[2][0].err), 32'd1);
      run(50);

      // All requesters continuously valid: strict rotation from requester 0.
      do_reset();
      for (int round = 0; round < 2; round++) begin
         for (int r = 0; r < NREQ; r++) begin
            add_word(IDW'(r), 16'($urandom), 1'b1, 1'($urandom_range(1)), 0);
         end
      end
      run(100);
      check("t3_count", 32'(id_log.size()), 32'd8);
      for (int i = 0; i < id_log.size(); i++) check("t3_order", 32'(id_log[i]), 32'(i % NREQ));

      // Requester 3 raises valid while requester 1 is mid-packet.
      do_reset();
      add_word(2'd1, 16'h1234, 1'b0, 1'b0, 0);
      add_word(2'd1, 16'h0F0F, 1'b0, 1'b0, 1);
      add_word(2'd1, 16'hA5A5, 1'b0, 1'b0, 0);
      add_word(2'd1, 16'h0101, 1'b1, 1'b1, 2);
      add_word(2'd3, 16'h7777, 1'b1, 1'b0, 2);
      run(100);
      check("t4_count", 32'(id_log.size()), 32'd2);
      if (id_log.size() == 2) begin
         check("t4_first", 32'(id_log[0]), 32'd1);
         check("t4_second", 32'(id_log[1]), 32'd3);
      end

      // Consumer stalls: response held, nothing else accepted.
      do_reset();
      rsp_pct = 0;
      add_word(2'd0, 16'h0007, 1'b1, 1'b0, 0);
      add_word(2'd1, 16'h0001, 1'b1, 1'b0, 0);
      add_word(2'd2, 16'h0700, 1'b1, 1'b0, 0);
      repeat (8) step();
      check("t5_hold_valid", 32'(rsp_valid), 32'd1);
      check("t5_hold_busy", 32'(busy), 32'd1);
      check("t5_hold_ready", 32'(req_ready), 32'd0);
      rsp_pct = 100;
      run(100);
`ifdef PARITY_SCHED_ERRCNT_EN
      check("t5_err_cnt", 32'(err_cnt), 32'd3);
`endif

      // Reset in the middle of a 4-word packet; the packet is then restarted.
      do_reset();
      pkt6[0] = 16'h1111; pkt6[1] = 16'h0303; pkt6[2] = 16'h8001; pkt6[3] = 16'h4000;
      for (int i = 0; i < 4; i++) add_word(2'd2, pkt6[i], 1'(i == 3), 1'b0, 0);
      for (int n = 0; n < 20 && wq[2].size() > 2; n++) step();
      check("t6_midpacket", 32'(wq[2].size()), 32'd2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      wq[2].delete();
      sb[2].delete();
      model_acc[2] = 1'b0;
      id_log.delete();
      check("t6_ready", 32'(req_ready), 32'd0);
      check("t6_par_in", 32'(par_in), 32'd0);
      check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
      check("t6_rsp_id", 32'(rsp_id), 32'd0);
      check("t6_rsp_parity", 32'(rsp_parity), 32'd0);
      check("t6_rsp_err", 32'(rsp_err), 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 4; i++) add_word(2'd2, pkt6[i], 1'(i == 3), 1'b0, 0);
      run(50);
      check("t6_one_response", 32'(id_log.size()), 32'd1);

      // Randomized traffic with random gaps, lengths and consumer back-pressure.
      do_reset();
      rsp_pct = 70;
      for (int p = 0; p < 40; p++) begin
         int r;
         int len;
         r   = int'($urandom_range(NREQ-1));
         len = int'($urandom_range(5, 1));
         for (int i = 0; i < len; i++) begin
            add_word(IDW'(r), 16'($urandom), 1'(i == len-1), 1'($urandom_range(1)),
                     int'($urandom_range(3)));
         end
      end
      run(5000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/parity_sched.md
# parity_sched

Round-robin scheduler that shares one combinational 16-input parity tree among `NREQ` requesters. Each requester streams a packet of 16-bit words. The block locks the tree to one requester per packet and accumulates the per-word parity across the whole packet. It then returns the packet parity and a mismatch flag against the requester's expected bit. It sits between the requester ports and the single parity-tree instance, which is driven through `par_in`/`par_q`.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, range 2..16.
- `IDW`, default `$clog2(NREQ)`: width of the requester index.

Ports:
- `clk`  in  1  sole clock; all logic rising-edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req_valid`  in  NREQ  per-requester word valid.
- `req_data`  in  NREQ*16  per-requester word; requester r uses bits [16r+15:16r].
- `req_last`  in  NREQ  marks the final word of a packet.
- `req_exp`  in  NREQ  expected packet parity, sampled with the last word.
- `req_ready`  out  NREQ  word accept, one-hot or zero.
- `par_in`  out  16  operand to the shared parity tree.
- `par_q`  in  1  tree result, defined as XOR of all `par_in` bits, combinational.
- `rsp_valid`  out  1  packet result available.
- `rsp_id`  out  IDW  requester that owns the result.
- `rsp_parity`  out  1  XOR of all words of the packet.
- `rsp_err`  out  1  equals `rsp_parity ^ exp`.
- `rsp_ready`  in  1  result consumer accept.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States are IDLE, STREAM and RESP.
- **IDLE**
  - If any `req_valid` is high, grant the first requester with valid high, searching upward from `ptr+1` modulo NREQ.
  - Register the grant index `g`, clear `acc`, and go to STREAM.
  - No word is accepted in the IDLE cycle.
- **STREAM**
  - `req_ready[g]=1`; all other ready bits are 0.
  - `par_in = req_data[g]`.
  - On `req_valid[g]`, `acc <= acc ^ par_q`.
  - If `req_last[g]` is also set, capture `req_exp[g]` and load `rsp_parity = acc ^ par_q` and `rsp_err`, then go to RESP.
  - If `req_valid[g]` is low, hold; no timeout and no preemption.
  - Other requesters' valids are ignored until the packet ends.
- **RESP**
  - `rsp_valid=1`; `rsp_id`, `rsp_parity` and `rsp_err` are stable.
  - On `rsp_ready`, set `ptr <= g` and go to IDLE.
- `par_in` is 0 outside STREAM and 0 while STREAM waits on a low valid.
- A single-word packet (valid and last in the first STREAM cycle) is legal.
- Packet length is unbounded; `acc` is 1 bit, so there is no overflow.

## Timing
- Reset values:
  - state IDLE, `ptr = NREQ-1` (requester 0 has first priority), `acc = 0`.
  - All outputs 0: `req_ready`, `par_in`, `rsp_*`, `busy`, and `err_cnt` when present.
- Grant-to-first-accept latency: 1 cycle. Valid seen in IDLE at cycle t gives ready at t+1.
- Throughput: 1 word/cycle inside a packet. Per-packet overhead is 1 IDLE cycle plus at least 1 RESP cycle.
- Last word accepted at cycle t: `rsp_valid` rises at t+1. The earliest next grant cycle is the cycle after `rsp_ready`.
- `rst` asserted in any state takes effect at the next edge.
  - A packet in flight is discarded and no response is produced.
  - The requester must restart the packet.
- Requesters may drop valid mid-packet; dropping valid does not release the grant.

## Configuration
- `PARITY_SCHED_ERRCNT_EN`
  - Defined: adds output `err_cnt` (out, 16). It increments on each RESP handshake (`rsp_valid & rsp_ready`) with `rsp_err=1`, saturates at 16'hFFFF, and clears only on `rst`.
  - Undefined: the port and the counter are absent; all other behaviour is identical.

## Test plan
- Reset, then requester 0 sends the single word 16'h0001 with last and exp=1 -> ready at cycle 2, `rsp_valid` at cycle 3 with id=0, parity=1, err=0.
- Requester 2 sends words 16'h00FF, 16'h0003, 16'h8000 (last, exp=0) with a 2-cycle valid gap after word 1 -> parity=1, err=1, ready held throughout the gap.
- All 4 requesters hold valid continuously with one-word packets -> grant order 0,1,2,3,0, with no requester granted twice before the others.
- Requester 1 mid-packet while requester 3 raises valid -> requester 3 is never ready until requester 1's response handshakes; requester 3 is granted next.
- `rsp_ready` held low for 5 cycles -> `rsp_*` stable, all `req_ready` low, `busy`=1; with the macro, 3 err packets give `err_cnt`=3.
- `rst` pulsed in the middle of a 4-word packet -> next cycle all outputs 0 and no response is issued; the restarted packet yields the correct parity.
